cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 133 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: accepts a miss, fetches one line from memory and
// writes it into the data/tag RAMs. Define CRITICAL_WORD_FIRST_EN to fetch the missed word first.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH        = 32,
    parameter int WORD_NUM          = 4,
    parameter int INDEX_WIDTH       = 7,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int ADDR_WIDTH        = 32
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  miss_valid,
    output logic                                                  miss_ready,
    input  logic [ADDR_WIDTH-1:0]                                 miss_addr,
    output logic                                                  mem_req,
    input  logic                                                  mem_gnt,
    output logic [ADDR_WIDTH-1:0]                                 mem_addr,
    input  logic                                                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                                 mem_rdata,
    output logic                                                  ram_we,
    output logic [INDEX_WIDTH-1:0]                                ram_index,
    output logic [WORD_OFFSET_WIDTH-1:0]                          ram_offset,
    output logic [DATA_WIDTH-1:0]                                 ram_data,
    output logic                                                  tag_we,
    output logic [ADDR_WIDTH-INDEX_WIDTH-WORD_OFFSET_WIDTH-3:0]   tag_out,
    output logic                                                  refill_done
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - WORD_OFFSET_WIDTH - 2;
    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = WORD_OFFSET_WIDTH'(WORD_NUM - 1);
`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);
`else
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~((ADDR_WIDTH'(1) << (WORD_OFFSET_WIDTH + 2)) - ADDR_WIDTH'(1));
`endif

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                         state_q, state_d;
    logic [WORD_OFFSET_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WORD_OFFSET_WIDTH-1:0]   start_q, start_d;
    logic [INDEX_WIDTH-1:0]         index_q, index_d;
    logic [TAG_WIDTH-1:0]           tag_q, tag_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic                           ram_we_q, ram_we_d;
    logic [INDEX_WIDTH-1:0]         ram_index_q, ram_index_d;
    logic [WORD_OFFSET_WIDTH-1:0]   ram_offset_q, ram_offset_d;
    logic [DATA_WIDTH-1:0]          ram_data_q, ram_data_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        index_d      = index_q;
        tag_d        = tag_q;
        addr_d       = addr_q;
        ram_we_d     = 1'b0;
        ram_index_d  = ram_index_q;
        ram_offset_d = ram_offset_q;
        ram_data_d   = ram_data_q;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    state_d = REQ;
                    index_d = miss_addr[WORD_OFFSET_WIDTH+2 +: INDEX_WIDTH];
                    tag_d   = miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    addr_d  = miss_addr & ADDR_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d = miss_addr[2 +: WORD_OFFSET_WIDTH];
`else
                    start_d = '0;
`endif
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                // Each beat is written one cycle later; the last one lands in DONE.
                if (mem_rvalid) begin
                    ram_we_d     = 1'b1;
                    ram_index_d  = index_q;
                    ram_offset_d = start_q + cnt_q;
                    ram_data_d   = mem_rdata;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            start_q      <= '0;
            index_q      <= '0;
            tag_q        <= '0;
            addr_q       <= '0;
            ram_we_q     <= 1'b0;
            ram_index_q  <= '0;
            ram_offset_q <= '0;
            ram_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            addr_q       <= addr_d;
            ram_we_q     <= ram_we_d;
            ram_index_q  <= ram_index_d;
            ram_offset_q <= ram_offset_d;
            ram_data_q   <= ram_data_d;
        end
    end

    assign miss_ready  = (state_q == IDLE);
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign ram_we      = ram_we_q;
    assign ram_index   = ram_index_q;
    assign ram_offset  = ram_offset_q;
    assign ram_data    = ram_data_q;
    assign tag_we      = (state_q == DONE);
    assign refill_done = (state_q == DONE);
    assign tag_out     = tag_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed and randomized refills checked
// against a line-level model (expected addresses, offsets, data order, latency).
module tb_cache_refill_ctrl;
    localparam int DW = 32, WN = 4, IW = 7, WOW = 2, AW = 32;
    localparam int TW = AW - IW - WOW - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_valid, miss_ready;
    logic [AW-1:0] miss_addr, mem_addr;
    logic          mem_req, mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata, ram_data;
    logic          ram_we, tag_we, refill_done;
    logic [IW-1:0] ram_index;
    logic [WOW-1:0] ram_offset;
    logic [TW-1:0] tag_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ram_we(ram_we), .ram_index(ram_index),
        .ram_offset(ram_offset), .ram_data(ram_data), .tag_we(tag_we), .tag_out(tag_out),
        .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // One refill. pat_len<0: random rvalid gaps; otherwise pat gives rvalid per fill cycle, then 1s.
    // abort_at>0 asserts reset right after that many writes have been observed.
    task automatic refill(input logic [AW-1:0] addr, input int gnt_dly, input logic [15:0] pat,
                          input int pat_len, input bit noise, input int abort_at, input bit chk_lat);
        int unsigned exp_index, exp_tag, start, exp_maddr;
        int cyc, nwr, beats, req_seen, rv_idx;
        bit granted, done;
        exp_index = (addr >> (WOW + 2)) % (1 << IW);
        exp_tag   = addr >> (AW - TW);
`ifdef CRITICAL_WORD_FIRST_EN
        start     = (addr >> 2) % WN;
        exp_maddr = addr - (addr % 4);
`else
        start     = 0;
        exp_maddr = addr - (addr % (WN * 4));
`endif
        exp_q.delete();
        @(negedge clk);
        check("ready_before_miss", miss_ready, 1);
        miss_valid = 1'b1; miss_addr = addr; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        cyc = 0; nwr = 0; beats = 0; req_seen = 0; rv_idx = 0; granted = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            miss_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            miss_addr  = $urandom;
            check("ready_busy", miss_ready, 0);
            if (mem_req) begin
                req_seen++;
                check("mem_addr", mem_addr, exp_maddr);
            end
            if (ram_we) begin
                check("ram_index", ram_index, exp_index);
                check("ram_offset", ram_offset, (start + nwr) % WN);
                check("ram_data", ram_data, (nwr < exp_q.size()) ? exp_q[nwr] : 'x);
                nwr++;
            end
            if (refill_done || tag_we) begin
                done = 1;
                miss_valid = 1'b0;
                check("done_tag_we", {refill_done, tag_we, ram_we}, 3'b111);
                check("tag_out", tag_out, exp_tag);
                check("writes_at_done", nwr, WN);
                check("req_cycles", req_seen, gnt_dly + 1);
                if (chk_lat) check("latency", cyc, WN + 2);
            end
            if (abort_at > 0 && nwr == abort_at) begin
                rst_n = 1'b0; miss_valid = 1'b0; mem_gnt = 1'b0;
                mem_rvalid = 1'b1; mem_rdata = $urandom;
                @(negedge clk);
                check("abort_outs", {ram_we, tag_we, refill_done, mem_req, miss_ready}, 5'b00001);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    mem_rvalid = 1'b1; mem_rdata = $urandom;
                    @(negedge clk);
                    check("stray_rvalid", {ram_we, tag_we, refill_done, miss_ready}, 4'b0001);
                end
                mem_rvalid = 1'b0;
                return;
            end
            mem_gnt = 1'b0;
            mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            if (granted && beats < WN) begin
                if (pat_len < 0)            mem_rvalid = 1'($urandom_range(0, 1));
                else if (rv_idx < pat_len)  mem_rvalid = pat[rv_idx];
                else                        mem_rvalid = 1'b1;
                rv_idx++;
                if (mem_rvalid) begin
                    exp_q.push_back(mem_rdata);
                    beats++;
                end
            end
            if (mem_req && !granted) begin
                mem_gnt = (req_seen == gnt_dly + 1);
                if (mem_gnt) granted = 1;
            end
        end
        if (!done) check("refill_timeout", 0, 1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check("ready_after", {miss_ready, ram_we, refill_done}, 3'b100);
    endtask

    initial begin
        rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", miss_ready, 1);
        check("rst_ctrl", {mem_req, ram_we, tag_we, refill_done}, 4'b0000);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ram_index", ram_index, 0);
        check("rst_ram_offset", ram_offset, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_tag_out", tag_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", miss_ready, 1);

        refill(32'h0000_1234, 0, 16'h0, 0, 1'b0, 0, 1'b1);
        refill(32'h0000_1234, 3, 16'b1011001, 7, 1'b1, 0, 1'b0);
        for (int i = 0; i < 8; i++)
            refill($urandom, $urandom_range(0, 3), 16'h0, -1, 1'b1, 0, 1'b0);
        refill($urandom, 0, 16'h0, 0, 1'b0, 2, 1'b0);
        refill(32'hFFFF_FFFC, 1, 16'h0, 0, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
